// File: rtl/spi_slave_bridge.sv
// SPI mode-0 target that turns serial frames into byte-wide bus accesses over a
// 256-byte window. All SPI pins are oversampled in clk_i; one bus request in flight.
module spi_slave_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sck_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic       bus_req_o,
  output logic       bus_we_o,
  output logic [7:0] bus_addr_o,
  output logic [7:0] bus_wdata_o,
  input  logic       bus_gnt_i,
  input  logic [7:0] bus_rdata_i,
  output logic       ovr_o
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE} state_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } bus_req_t;

  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] CMD_RD = 8'h0B;

  // synchronizers; MOSI gets the same depth so it stays aligned with SCK
  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic sck_s, csn_s, mosi_s, sck_q, csn_q;
  logic sck_rise, sck_fall, csn_fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      csn_q     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_q     <= sck_s;
      csn_q     <= csn_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q & ~csn_s;
  assign sck_fall = ~sck_s & sck_q & ~csn_s;
  assign csn_fall = ~csn_s & csn_q;

  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] rx_byte;
  logic       byte_end;

  assign rx_byte  = {rx_sh, mosi_s};
  assign byte_end = sck_rise & (bit_cnt == 3'd7);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= 3'd0;
      rx_sh   <= 7'd0;
    end else if (csn_s) begin
      bit_cnt <= 3'd0;
    end else if (sck_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sh   <= rx_byte[6:0];
    end
  end

  state_t   state, state_nx;
  logic     cmd_rd;
  logic     addr_load, rd_start, wr_fire, tx_load;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    addr_load = 1'b0;
    rd_start  = 1'b0;
    wr_fire   = 1'b0;
    tx_load   = 1'b0;
    if (csn_s) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (csn_fall) state_nx = CMD;
        CMD:   if (byte_end)
                 state_nx = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? ADDR : IGNORE;
        ADDR:  if (byte_end) begin
                 state_nx  = cmd_rd ? DUMMY : WDATA;
                 addr_load = 1'b1;
                 rd_start  = cmd_rd;
               end
        DUMMY: if (byte_end) state_nx = RDATA;
        WDATA: wr_fire = byte_end;
        // a falling edge with the counter at 0 is the start of a TX byte
        RDATA: tx_load = sck_fall & (bit_cnt == 3'd0);
        default: ;
      endcase
    end
  end

  bus_req_t req_q;
  logic     req_vld;
  logic [7:0] addr, rd_buf, tx_sh;
  logic     rd_want, rd_valid, rd_drop, oe_q, ovr_q;
  logic     rd_pending;

  // a read that is still outstanding when its data is no longer wanted gets discarded
  assign rd_pending = req_vld & ~req_q.we & ~bus_gnt_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_vld  <= 1'b0;
      req_q    <= '0;
      addr     <= 8'h00;
      cmd_rd   <= 1'b0;
      rd_want  <= 1'b0;
      rd_valid <= 1'b0;
      rd_drop  <= 1'b0;
      rd_buf   <= 8'h00;
      tx_sh    <= 8'h00;
      oe_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (state == CMD && byte_end) cmd_rd <= (rx_byte == CMD_RD);

      if (req_vld && bus_gnt_i) begin
        req_vld <= 1'b0;
        if (!req_q.we) begin
          if (!rd_drop) begin
            rd_valid <= 1'b1;
            rd_buf   <= bus_rdata_i;
          end
          rd_drop <= 1'b0;
        end
      end

      if (addr_load) addr <= rx_byte;
      if (rd_start)  rd_want <= 1'b1;

      if (wr_fire) begin
        addr <= addr + 8'd1;
        if (req_vld) ovr_q <= 1'b1;
        else begin
          req_vld <= 1'b1;
          req_q   <= '{we: 1'b1, addr: addr, wdata: rx_byte};
        end
      end else if (rd_want && !req_vld && !csn_s) begin
        req_vld <= 1'b1;
        req_q   <= '{we: 1'b0, addr: addr, wdata: 8'h00};
        addr    <= addr + 8'd1;
        rd_want <= 1'b0;
      end

      if (csn_s || state != RDATA) oe_q <= 1'b0;

      if (tx_load) begin
        tx_sh    <= rd_valid ? rd_buf : 8'h00;
        rd_valid <= 1'b0;
        rd_want  <= 1'b1;
        oe_q     <= 1'b1;
        if (!rd_valid) begin
          ovr_q <= 1'b1;
          if (rd_pending) rd_drop <= 1'b1;
        end
      end else if (state != RDATA) begin
        tx_sh <= 8'h00;
      end else if (sck_fall) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end

      if (csn_s) begin
        rd_want  <= 1'b0;
        rd_valid <= 1'b0;
        if (rd_pending) rd_drop <= 1'b1;
      end
    end
  end

  assign spi_miso_o    = (state == RDATA) & tx_sh[7];
  assign spi_miso_oe_o = oe_q;
  assign bus_req_o     = req_vld;
  assign bus_we_o      = req_q.we;
  assign bus_addr_o    = req_q.addr;
  assign bus_wdata_o   = req_q.wdata;
  assign ovr_o         = ovr_q;

endmodule
